// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that owns the select lines of a shared 4:1 data mux.
// An owner keeps the mux while it requests, bounded by MAX_HOLD under contention.
module mux4_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       valid
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_t     state_reg;
    logic [1:0] ptr_reg;
    logic [3:0] hold_cnt_reg;
    logic [3:0] gnt_reg;
    logic [1:0] sel_reg;
    logic       valid_reg;

    logic [3:0] owner_onehot;
    logic [3:0] others_req;
    logic       owner_req;
    logic       others_pending;
    logic       hold_expired;
    logic [1:0] search_start;
    logic       pick_found;
    logic [1:0] pick_idx;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_owner
            assign owner_onehot[gi] = (ptr_reg == 2'(gi));
        end
    endgenerate

    // ptr_reg is both the current owner (in GRANT) and the last owner (in IDLE),
    // so the search always begins one past it.
    assign search_start   = ptr_reg + 2'd1;
    assign others_req     = req & ~owner_onehot;
    assign owner_req      = |(req & owner_onehot);
    assign others_pending = |others_req;
    assign hold_expired   = (hold_cnt_reg >= HOLD_LAST);

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!pick_found && req[search_start + 2'(i)]) begin
                pick_found = 1'b1;
                pick_idx   = search_start + 2'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            ptr_reg      <= 2'd3;
            hold_cnt_reg <= 4'd0;
            gnt_reg      <= 4'b0000;
            sel_reg      <= 2'd0;
            valid_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_found) begin
                        state_reg    <= GRANT;
                        ptr_reg      <= pick_idx;
                        hold_cnt_reg <= 4'd0;
                        gnt_reg      <= 4'b0001 << pick_idx;
                        sel_reg      <= pick_idx;
                        valid_reg    <= 1'b1;
                    end
                end
                GRANT: begin
                    if (owner_req && (!others_pending || !hold_expired)) begin
                        // Sole contender saturates here and is never forced off.
                        if (!hold_expired) begin
                            hold_cnt_reg <= hold_cnt_reg + 4'd1;
                        end
                    end else if (others_pending) begin
                        state_reg    <= GRANT;
                        ptr_reg      <= pick_idx;
                        hold_cnt_reg <= 4'd0;
                        gnt_reg      <= 4'b0001 << pick_idx;
                        sel_reg      <= pick_idx;
                        valid_reg    <= 1'b1;
                    end else begin
                        state_reg    <= IDLE;
                        hold_cnt_reg <= 4'd0;
                        gnt_reg      <= 4'b0000;
                        valid_reg    <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    gnt_reg   <= 4'b0000;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign gnt   = gnt_reg;
    assign sel   = sel_reg;
    assign valid = valid_reg;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: a vector table plus hand sequences for
// hold rotation, sole-requester saturation and asynchronous reset.
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;

    int errors;
    int checks;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       valid;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs[NVEC];

    mux4_rr_arbiter #(.MAX_HOLD(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .gnt   (gnt),
        .sel   (sel),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [3:0] eg,
                         input logic [1:0] es, input logic ev);
        checks++;
        if (gnt !== eg || sel !== es || valid !== ev) begin
            errors++;
            $display("FAIL %s: got gnt=%b sel=%b valid=%b, want gnt=%b sel=%b valid=%b",
                     name, gnt, sel, valid, eg, es, ev);
        end else begin
            $display("ok   %s: req=%b gnt=%b sel=%b valid=%b", name, req, gnt, sel, valid);
        end
    endtask

    // Apply req shortly after an edge, then sample just after the next edge.
    task automatic step(input logic [3:0] r);
        req = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b1;
        req    = 4'b0000;

        // Table: each row follows from the previous one.
        vecs[0]  = '{4'b0001, 4'b0001, 2'd0, 1'b1}; // first grant to 0
        vecs[1]  = '{4'b0101, 4'b0001, 2'd0, 1'b1}; // owner 0 holds
        vecs[2]  = '{4'b0100, 4'b0100, 2'd2, 1'b1}; // drop -> direct handover
        vecs[3]  = '{4'b0000, 4'b0000, 2'd2, 1'b0}; // idle, sel stays 2
        vecs[4]  = '{4'b0101, 4'b0001, 2'd0, 1'b1}; // ptr=2: order 3,0,1,2
        vecs[5]  = '{4'b0000, 4'b0000, 2'd0, 1'b0};
        vecs[6]  = '{4'b0101, 4'b0100, 2'd2, 1'b1}; // ptr=0: order 1,2
        vecs[7]  = '{4'b0000, 4'b0000, 2'd2, 1'b0};
        vecs[8]  = '{4'b1010, 4'b1000, 2'd3, 1'b1}; // order 3,0,1,2
        vecs[9]  = '{4'b0110, 4'b0010, 2'd1, 1'b1}; // owner 3 drops: order 0,1
        vecs[10] = '{4'b1100, 4'b0100, 2'd2, 1'b1}; // owner 1 drops: order 2,3
        vecs[11] = '{4'b0000, 4'b0000, 2'd2, 1'b0};

        // Reset state, with req already high before the first edge.
        rst_n = 1'b0;
        #7;
        check("async_reset_assert", 4'b0000, 2'd0, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        req   = 4'b0001;
        #1;
        check("before_first_edge", 4'b0000, 2'd0, 1'b0);

        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].req);
            check($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].sel, vecs[i].valid);
        end

        // Full contention: each owner exactly 8 grant cycles, no bubbles.
        do_reset();
        for (int n = 1; n <= 40; n++) begin
            logic [1:0] own;
            own = 2'(((n - 1) / 8) % 4);
            step(4'b1111);
            check($sformatf("hold_rot_c%0d", n), 4'b0001 << own, own, 1'b1);
        end

        // Sole requester holds indefinitely, then releases to idle.
        step(4'b0000);
        check("rot_release", 4'b0000, 2'd0, 1'b0);
        for (int n = 1; n <= 20; n++) begin
            step(4'b1000);
            check($sformatf("sole3_c%0d", n), 4'b1000, 2'd3, 1'b1);
        end
        step(4'b0000);
        check("sole3_release", 4'b0000, 2'd3, 1'b0);

        // Saturated owner: a new request is serviced on the very next edge.
        for (int n = 1; n <= 12; n++) begin
            step(4'b0001);
        end
        check("sat_owner0", 4'b0001, 2'd0, 1'b1);
        step(4'b0011);
        check("sat_contend_rotate", 4'b0010, 2'd1, 1'b1);

        // Hold expiry coinciding with a newly raised request.
        step(4'b0000);
        for (int n = 1; n <= 7; n++) begin
            step(4'b0100);
        end
        check("expiry_pre", 4'b0100, 2'd2, 1'b1);
        step(4'b0110);
        check("expiry_hold_cnt7", 4'b0100, 2'd2, 1'b1);
        step(4'b0110);
        check("expiry_rotate", 4'b0010, 2'd1, 1'b1);

        // Asynchronous reset between edges, then restart from ptr=3.
        #4;
        rst_n = 1'b0;
        #1;
        check("midgrant_async_reset", 4'b0000, 2'd0, 1'b0);
        req = 4'b0010;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_grant1", 4'b0010, 2'd1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 data mux between four requesters.
- Drives the mux select lines and a one-hot grant back to the requesters.
- A granted requester keeps the mux while its request stays high, up to a bounded hold time when others are waiting.
- Sits directly in front of the 4:1 mux; its sel[1] and sel[0] drive the mux s1 and s0 inputs.

Parameters:
- MAX_HOLD, 8: maximum consecutive grant cycles for one requester while another request is pending. Legal range 1..15.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  request vector; req[i] high means requester i wants the mux.
- gnt  output  4  one-hot grant, registered; all-zero when idle.
- sel  output  2  binary index of the current/last owner, registered; drives the mux select (sel[1]=s1, sel[0]=s0).
- valid  output  1  high when gnt is non-zero, registered.

Behaviour:
- Reset (rst_n low, asynchronous, effective immediately regardless of clk):
  - gnt=0000, sel=00, valid=0.
  - State=IDLE, hold_cnt=0.
  - Last-owner pointer ptr=3, so index 0 has first priority.
- State machine, two states: IDLE and GRANT.
- All outputs are registered. Latency from a req edge-sample to gnt/sel/valid is 1 clock.
- Search order is cyclic starting at ptr+1 mod 4. The first index with req high at the sampling edge wins.
- IDLE:
  - req==0000: stay in IDLE; gnt=0000, valid=0, sel keeps its last value.
  - Any req bit high: go to GRANT with winner w. Set gnt=onehot(w), sel=w, valid=1, ptr=w, hold_cnt=0.
- GRANT, owner k:
  - req[k]=1, no other req, or hold_cnt<MAX_HOLD-1: keep the grant. hold_cnt increments, saturating at MAX_HOLD-1.
  - req[k]=1, another req pending, and hold_cnt==MAX_HOLD-1: forced rotation. Grant the next requester after k (search from k+1) on the next edge, with hold_cnt=0.
  - req[k]=0, others pending: hand over directly to the next requester searched from k+1. No idle bubble; gnt changes in one edge.
  - req[k]=0, no others pending: return to IDLE. gnt=0000, valid=0, sel stays k.
- hold_cnt counts grant cycles of the current owner. The cycle a grant is issued counts as the first cycle (hold_cnt=0).
- Single contender: a sole requester may hold the mux indefinitely. The counter saturates and no forced release occurs.
- Simultaneous events:
  - Owner drops while several others raise requests in the same cycle: the round-robin search from k+1 decides.
  - A request that goes high in the same cycle the hold expires is counted as pending.
- Grant is never issued to an index whose req is low at the deciding edge.
- gnt is always one-hot or zero. valid==|gnt. When valid=1, sel always equals the encoded gnt.
- No combinational path from req to any output.

Test Plan:
- Reset, then req=0001 from cycle 0 -> at edge 1: gnt=0001, sel=00, valid=1. Before edge 1: all outputs zero.
- MAX_HOLD=8, req=1111 held 40 cycles -> grant sequence 0,1,2,3,0 with exactly 8 cycles each. sel steps 00,01,10,11,00. No cycle with valid=0.
- Owner 0 holding, req=0101, then req[0] drops -> on the next edge gnt=0100, sel=10, valid stays 1 (no bubble).
- req=1000 alone for 20 cycles -> gnt=1000 and sel=11 for all 20. Then req=0000 -> next edge gnt=0000, valid=0, sel stays 11.
- After owner 2 releases to IDLE (ptr=2), apply req=0101 -> gnt=0001 (search order 3,0,1,2). Release, then req=0101 again -> gnt=0100.
- Pull rst_n low mid-grant between clock edges -> gnt=0000, sel=00, valid=0 immediately. Release with req=0010 -> next edge gnt=0010, sel=01.
